alu_math_sched: RTL and testbench

- Round-robin scheduler that shares one alu_math datapath between NUM_REQ requesters.
- Accepts a whole command (op, A, B) in parallel from a requester.
- Serialises the command onto the ALU's byte-wide ctl/dat stream, waits for the ALU's ready, then returns the 32-bit result to the requester that owns the command.
- Sits between the client blocks and alu_math; it is the only driver of the ALU's ctl/dat inputs.

---
 rtl/alu_math_pkg.sv | 31 +++
 rtl/alu_math_sched_if.sv | 23 ++
 rtl/alu_math_rr_arb.sv | 28 ++
 rtl/alu_math_sched.sv | 135 +++++++++++++
 tb/tb_alu_math_sched.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_math_pkg.sv
// Shared opcode, state and operand-usage definitions for the alu_math scheduler.
package alu_math_pkg;

  typedef enum logic [3:0] {
    ADD_A_B = 4'd0,
    SUB_A_B = 4'd1,
    MUL_A_B = 4'd2,
    AND_A_B = 4'd3,
    OR_A_B  = 4'd4,
    XOR_A_B = 4'd5,
    INC_A   = 4'd6,
    INC_B   = 4'd7,
    CLR_RES = 4'd8,
    ACCUM   = 4'd9
  } op_e;

  localparam logic [3:0] OP_MAX = 4'd9;

  typedef enum logic [2:0] {
    IDLE, SEND_OP, A_MSB, A_LSB, B_MSB, B_LSB, WAIT_RDY, RESP
  } state_e;

  function automatic logic needs_a(input logic [3:0] op);
    return (op <= XOR_A_B) || (op == INC_A) || (op == ACCUM);
  endfunction

  function automatic logic needs_b(input logic [3:0] op);
    return (op <= XOR_A_B) || (op == INC_B);
  endfunction

endpackage

// File: rtl/alu_math_sched_if.sv
// Requester-side command/response bundle of the alu_math scheduler.
interface alu_math_sched_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req;
  logic [4*NUM_REQ-1:0]  req_op;
  logic [16*NUM_REQ-1:0] req_a;
  logic [16*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    done;
  logic [31:0]           rsp_result;
  logic                  rsp_err;

  modport master (
    output req, req_op, req_a, req_b,
    input  gnt, done, rsp_result, rsp_err
  );

  modport slave (
    input  req, req_op, req_a, req_b,
    output gnt, done, rsp_result, rsp_err
  );
endinterface

// File: rtl/alu_math_rr_arb.sv
// One-hot round-robin arbiter: search starts just after ptr and wraps.
module alu_math_rr_arb #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);
  int cand;

  // Walk from the farthest candidate to the nearest so the nearest match wins.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    cand = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (enable && req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        idx       = IDX_W'(cand);
      end
    end
  end
endmodule

// File: rtl/alu_math_sched.sv
// Round-robin scheduler serialising whole commands onto the shared alu_math byte stream.
// Optional WAIT_RDY timeout plus post-timeout drain: define ALU_MATH_SCHED_TIMEOUT_EN.
module alu_math_sched
  import alu_math_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_math_sched_if.slave cmd,
  output logic            busy,
  output logic            alu_ctl,
  output logic [7:0]      alu_dat,
  input  logic            alu_ready,
  input  logic [31:0]     alu_result
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e             state, nxt;
  logic [IDX_W-1:0]   ptr, owner, arb_idx;
  logic [NUM_REQ-1:0] arb_gnt;
  logic               arb_en, grant, illegal, timeout, draining;
  logic [3:0]         grant_op, cmd_op;
  logic [15:0]        cmd_a, cmd_b;
  logic [31:0]        res;
  logic               err;

`ifdef ALU_MATH_SCHED_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic [2:0]  drain;

  assign timeout  = (state == WAIT_RDY) && !alu_ready && (tmo_cnt == 16'(TIMEOUT_CYC - 1));
  assign draining = (drain != 3'd0);

  // Counter sits at zero outside WAIT_RDY, so it is cleared on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      drain   <= '0;
    end else begin
      tmo_cnt <= (state == WAIT_RDY) ? tmo_cnt + 16'd1 : 16'd0;
      if (timeout)
        drain <= 3'd4;
      else if (state == IDLE && draining)
        drain <= drain - 3'd1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign timeout            = 1'b0;
  assign draining           = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
`endif

  // Grants are suppressed while reset is asserted so every output reads zero.
  assign arb_en = rst_n && (state == IDLE) && !draining;

  alu_math_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req    (cmd.req),
    .ptr    (ptr),
    .enable (arb_en),
    .gnt    (arb_gnt),
    .idx    (arb_idx)
  );

  assign grant    = |arb_gnt;
  assign grant_op = cmd.req_op[4*int'(arb_idx) +: 4];
  assign illegal  = grant_op > OP_MAX;
  assign cmd.gnt  = arb_gnt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (grant) nxt = illegal ? RESP : SEND_OP;
      SEND_OP:  nxt = needs_a(cmd_op) ? A_MSB : (needs_b(cmd_op) ? B_MSB : WAIT_RDY);
      A_MSB:    nxt = A_LSB;
      A_LSB:    nxt = needs_b(cmd_op) ? B_MSB : WAIT_RDY;
      B_MSB:    nxt = B_LSB;
      B_LSB:    nxt = WAIT_RDY;
      WAIT_RDY: if (alu_ready || timeout) nxt = RESP;
      RESP:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_comb begin
    alu_ctl = 1'b0;
    alu_dat = 8'h00;
    case (state)
      SEND_OP: begin
        alu_ctl = 1'b1;
        alu_dat = {4'h0, cmd_op};
      end
      A_MSB:   alu_dat = cmd_a[15:8];
      A_LSB:   alu_dat = cmd_a[7:0];
      B_MSB:   alu_dat = cmd_b[15:8];
      B_LSB:   alu_dat = cmd_b[7:0];
      default: ;
    endcase
  end

  assign busy           = (state != IDLE) || draining;
  assign cmd.done       = (state == RESP) ? (NUM_REQ'(1) << owner) : '0;
  assign cmd.rsp_result = (state == RESP) ? res : 32'h0;
  assign cmd.rsp_err    = (state == RESP) && err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= IDX_W'(NUM_REQ - 1);
    end else begin
      state <= nxt;
      if (grant) ptr <= arb_idx;
    end
  end

  // Command and result holding registers; only read in states reset already guards.
  always_ff @(posedge clk) begin
    if (grant) begin
      cmd_op <= grant_op;
      cmd_a  <= cmd.req_a[16*int'(arb_idx) +: 16];
      cmd_b  <= cmd.req_b[16*int'(arb_idx) +: 16];
      owner  <= arb_idx;
      err    <= illegal;
      res    <= 32'h0;
    end else if (state == WAIT_RDY && alu_ready) begin
      res <= alu_result;
      err <= 1'b0;
    end else if (timeout) begin
      res <= 32'h0;
      err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_math_sched.sv
// Self-checking bench for alu_math_sched: randomized commands against a byte-stream reference model.
module tb_alu_math_sched;
  localparam int NR = 3;

  typedef logic [7:0] byteq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_ready = 1'b0;
  logic [31:0] alu_result = 32'h0;
  logic        busy, alu_ctl;
  logic [7:0]  alu_dat;

  logic [NR-1:0] req_v = '0;
  logic [3:0]    p_op [NR];
  logic [15:0]   p_a  [NR];
  logic [15:0]   p_b  [NR];

  int n_tests = 0;
  int n_fail  = 0;
  int m_ptr   = NR - 1;

  always #5 clk = ~clk;

  alu_math_sched_if #(.NUM_REQ(NR)) bif ();

  always_comb begin
    bif.req    = req_v;
    bif.req_op = '0;
    bif.req_a  = '0;
    bif.req_b  = '0;
    for (int i = 0; i < NR; i++) begin
      bif.req_op[4*i +: 4]  = p_op[i];
      bif.req_a[16*i +: 16] = p_a[i];
      bif.req_b[16*i +: 16] = p_b[i];
    end
  end

  alu_math_sched #(.NUM_REQ(NR), .TIMEOUT_CYC(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (bif.slave),
    .busy       (busy),
    .alu_ctl    (alu_ctl),
    .alu_dat    (alu_dat),
    .alu_ready  (alu_ready),
    .alu_result (alu_result)
  );

  // Bytes the ALU must see for one command, straight from the opcode table.
  function automatic byteq_t exp_bytes(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    byteq_t q;
    q.push_back({4'h0, op});
    if (op <= 4'd5) begin
      q.push_back(a[15:8]); q.push_back(a[7:0]);
      q.push_back(b[15:8]); q.push_back(b[7:0]);
    end else if (op == 4'd6 || op == 4'd9) begin
      q.push_back(a[15:8]); q.push_back(a[7:0]);
    end else if (op == 4'd7) begin
      q.push_back(b[15:8]); q.push_back(b[7:0]);
    end
    return q;
  endfunction

  function automatic int pick();
    int c;
    for (int k = 1; k <= NR; k++) begin
      c = (m_ptr + k) % NR;
      if (req_v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0] onehot(input int i);
    logic [NR-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [3:0] rand_op();
    if ($urandom_range(0, 7) == 0) return 4'($urandom_range(10, 15));
    return 4'($urandom_range(0, 9));
  endfunction

  task automatic set_rand(input int i);
    p_op[i] = rand_op();
    p_a[i]  = 16'($urandom);
    p_b[i]  = 16'($urandom);
  endtask

  // Called just after a negedge with this IDLE cycle's inputs driven; ends in the RESP cycle.
  task automatic serve(input int delay, input logic [31:0] result, input bit reload, output int who);
    int w;
    logic [3:0] op;
    logic [15:0] a, b;
    byteq_t q;
    #1;
    w = pick();
    who = w;
    n_tests++;
    if (bif.gnt !== onehot(w)) begin
      n_fail++;
      $display("FAIL grant: got %b expected %b", bif.gnt, onehot(w));
    end
    if (w < 0) return;
    op = p_op[w]; a = p_a[w]; b = p_b[w];
    m_ptr = w;
    q = exp_bytes(op, a, b);
    @(negedge clk);
    if (reload) set_rand(w);
    else req_v[w] = 1'b0;
    if (op > 4'd9) begin
      #1;
      n_tests++;
      if ({bif.done, bif.rsp_err, bif.rsp_result, alu_ctl, busy} !== {onehot(w), 1'b1, 32'h0, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL illegal_resp: got done=%b err=%b res=%h ctl=%b expected done=%b err=1 res=0 ctl=0",
                 bif.done, bif.rsp_err, bif.rsp_result, alu_ctl, onehot(w));
      end
      return;
    end
    foreach (q[k]) begin
      if (k > 0) @(negedge clk);
      #1;
      n_tests++;
      if ({alu_ctl, alu_dat, busy, bif.gnt, bif.done} !== {k == 0, q[k], 1'b1, {NR{1'b0}}, {NR{1'b0}}}) begin
        n_fail++;
        $display("FAIL byte%0d: got ctl=%b dat=%h busy=%b gnt=%b done=%b expected ctl=%b dat=%h busy=1",
                 k, alu_ctl, alu_dat, busy, bif.gnt, bif.done, k == 0, q[k]);
      end
    end
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      alu_result = $urandom;
      #1;
      n_tests++;
      if ({alu_ctl, alu_dat, busy, bif.done} !== {1'b0, 8'h00, 1'b1, {NR{1'b0}}}) begin
        n_fail++;
        $display("FAIL wait%0d: got ctl=%b dat=%h busy=%b done=%b expected 0,00,1,0", d, alu_ctl, alu_dat, busy, bif.done);
      end
    end
    @(negedge clk);
    alu_ready = 1'b1;
    alu_result = result;
    #1;
    n_tests++;
    if ({busy, bif.done} !== {1'b1, {NR{1'b0}}}) begin
      n_fail++;
      $display("FAIL ready_cycle: got busy=%b done=%b expected busy=1 done=0", busy, bif.done);
    end
    @(negedge clk);
    alu_ready = 1'b0;
    alu_result = $urandom;
    #1;
    n_tests++;
    if ({bif.done, bif.rsp_err, bif.rsp_result, bif.gnt} !== {onehot(w), 1'b0, result, {NR{1'b0}}}) begin
      n_fail++;
      $display("FAIL resp: got done=%b err=%b res=%h gnt=%b expected done=%b err=0 res=%h gnt=0",
               bif.done, bif.rsp_err, bif.rsp_result, bif.gnt, onehot(w), result);
    end
  endtask

  task automatic test_reset();
    req_v = '1;
    for (int i = 0; i < NR; i++) begin p_op[i] = 4'd0; p_a[i] = 16'h0; p_b[i] = 16'h0; end
    @(negedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if ({bif.gnt, bif.done, bif.rsp_result, bif.rsp_err, busy, alu_ctl, alu_dat} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got gnt=%b done=%b res=%h err=%b busy=%b ctl=%b dat=%h expected all 0",
               bif.gnt, bif.done, bif.rsp_result, bif.rsp_err, busy, alu_ctl, alu_dat);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req_v = '0;
    m_ptr = NR - 1;
    @(negedge clk);
    #1;
    n_tests++;
    if ({bif.gnt, busy} !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got gnt=%b busy=%b expected 0", bif.gnt, busy);
    end
  endtask

  task automatic test_round_robin();
    int who;
    int exp_seq [3] = '{0, 1, 0};
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      set_rand(i);
      p_op[i] = 4'($urandom_range(0, 9));
    end
    req_v = 3'b011;
    for (int n = 0; n < 3; n++) begin
      if (n > 0) @(negedge clk);
      serve($urandom_range(0, 3), $urandom, 1'b1, who);
      n_tests++;
      if (who !== exp_seq[n]) begin
        n_fail++;
        $display("FAIL rr_order%0d: got %0d expected %0d", n, who, exp_seq[n]);
      end
    end
    req_v = '0;
  endtask

  task automatic test_add();
    int who;
    @(negedge clk);
    p_op[0] = 4'd0; p_a[0] = 16'h0102; p_b[0] = 16'h0304;
    req_v = 3'b001;
    serve(2, 32'h0000_0055, 1'b0, who);
  endtask

  task automatic test_short_ops();
    int who;
    @(negedge clk);
    p_op[2] = 4'd7; p_a[2] = 16'hBEEF; p_b[2] = 16'h00FF;
    req_v = 3'b100;
    serve(1, 32'hCAFE_0007, 1'b0, who);
    @(negedge clk);
    p_op[1] = 4'd8; p_a[1] = 16'h1111; p_b[1] = 16'h2222;
    req_v = 3'b010;
    serve(0, 32'h0, 1'b0, who);
    @(negedge clk);
    p_op[0] = 4'd6; p_a[0] = 16'hA55A; p_b[0] = 16'h3333;
    req_v = 3'b001;
    serve(3, 32'h0000_A55B, 1'b0, who);
    @(negedge clk);
    p_op[2] = 4'd9; p_a[2] = 16'h7F80; p_b[2] = 16'h4444;
    req_v = 3'b100;
    serve(0, 32'hFFFF_FFFF, 1'b0, who);
  endtask

  task automatic test_illegal();
    int who;
    @(negedge clk);
    p_op[0] = 4'hC; p_a[0] = 16'h1234; p_b[0] = 16'h5678;
    req_v = 3'b001;
    serve(0, 32'h0, 1'b0, who);
    @(negedge clk);
    #1;
    n_tests++;
    if ({busy, alu_ctl, bif.done} !== '0) begin
      n_fail++;
      $display("FAIL illegal_idle: got busy=%b ctl=%b done=%b expected 0", busy, alu_ctl, bif.done);
    end
  endtask

  task automatic test_late_ready();
    @(negedge clk);
    alu_ready = 1'b1;
    alu_result = 32'hDEAD_BEEF;
    #1;
    n_tests++;
    if ({busy, bif.done} !== '0) begin
      n_fail++;
      $display("FAIL stray_ready: got busy=%b done=%b expected 0", busy, bif.done);
    end
    @(negedge clk);
    alu_ready = 1'b0;
    #1;
    n_tests++;
    if ({busy, bif.done, bif.rsp_result} !== '0) begin
      n_fail++;
      $display("FAIL stray_ready_after: got busy=%b done=%b res=%h expected 0", busy, bif.done, bif.rsp_result);
    end
  endtask

  task automatic test_reset_mid();
    int who;
    @(negedge clk);
    p_op[1] = 4'd0; p_a[1] = 16'h1234; p_b[1] = 16'hABCD;
    req_v = 3'b010;
    #1;
    n_tests++;
    if (bif.gnt !== 3'b010) begin
      n_fail++;
      $display("FAIL mid_grant: got %b expected 010", bif.gnt);
    end
    @(negedge clk);
    req_v = '0;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if ({alu_ctl, alu_dat} !== {1'b0, 8'hAB}) begin
      n_fail++;
      $display("FAIL mid_bmsb: got ctl=%b dat=%h expected ctl=0 dat=ab", alu_ctl, alu_dat);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bif.gnt, bif.done, bif.rsp_result, bif.rsp_err, busy, alu_ctl, alu_dat} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got gnt=%b done=%b res=%h err=%b busy=%b ctl=%b dat=%h expected all 0",
               bif.gnt, bif.done, bif.rsp_result, bif.rsp_err, busy, alu_ctl, alu_dat);
    end
    for (int i = 0; i < 2; i++) begin
      set_rand(i);
      p_op[i] = 4'($urandom_range(0, 9));
    end
    req_v = 3'b011;
    @(negedge clk);
    #1;
    n_tests++;
    if ({bif.gnt, bif.done, busy} !== '0) begin
      n_fail++;
      $display("FAIL held_reset: got gnt=%b done=%b busy=%b expected 0", bif.gnt, bif.done, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = NR - 1;
    serve(1, $urandom, 1'b0, who);
    n_tests++;
    if (who !== 0) begin
      n_fail++;
      $display("FAIL post_reset_first: got %0d expected 0", who);
    end
    @(negedge clk);
    serve(0, $urandom, 1'b0, who);
    n_tests++;
    if (who !== 1) begin
      n_fail++;
      $display("FAIL post_reset_second: got %0d expected 1", who);
    end
  endtask

  task automatic test_random();
    int who;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (!req_v[i] && $urandom_range(0, 1) == 1) begin
          set_rand(i);
          req_v[i] = 1'b1;
        end
      end
      serve($urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)), who);
    end
    req_v = '0;
  endtask

  task automatic test_timeout();
`ifdef ALU_MATH_SCHED_TIMEOUT_EN
    int who;
    bit ok;
    @(negedge clk);
    p_op[0] = 4'd8; p_a[0] = 16'h0; p_b[0] = 16'h0;
    req_v = 3'b001;
    #1;
    n_tests++;
    if (bif.gnt !== onehot(pick())) begin
      n_fail++;
      $display("FAIL to_grant: got %b expected %b", bif.gnt, onehot(pick()));
    end
    m_ptr = pick();
    @(negedge clk);
    p_op[0] = 4'd0;
    #1;
    n_tests++;
    if ({alu_ctl, alu_dat} !== {1'b1, 8'h08}) begin
      n_fail++;
      $display("FAIL to_sendop: got ctl=%b dat=%h expected 1,08", alu_ctl, alu_dat);
    end
    ok = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      #1;
      if (bif.done !== '0 || busy !== 1'b1) ok = 1'b0;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL to_wait: got early done or idle during 16 wait cycles, expected none");
    end
    @(negedge clk);
    #1;
    n_tests++;
    if ({bif.done, bif.rsp_err, bif.rsp_result} !== {onehot(m_ptr), 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL to_resp: got done=%b err=%b res=%h expected done=%b err=1 res=0",
               bif.done, bif.rsp_err, bif.rsp_result, onehot(m_ptr));
    end
    ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      alu_ready = (c == 1);
      alu_result = 32'h1234_5678;
      #1;
      if (bif.gnt !== '0 || busy !== 1'b1 || bif.done !== '0) ok = 1'b0;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL to_drain: got grant, done or idle during the 4 drain cycles, expected none");
    end
    @(negedge clk);
    alu_ready = 1'b0;
    serve(1, 32'h0000_0077, 1'b0, who);
`endif
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin p_op[i] = 4'd0; p_a[i] = 16'h0; p_b[i] = 16'h0; end
    test_reset();
    test_round_robin();
    test_add();
    test_short_ops();
    test_illegal();
    test_late_ready();
    test_reset_mid();
    test_random();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
